// File: rtl/wb_arbiter.sv
// Writeback stage: merges ALU and load-unit results into an in-order FIFO
// that drains one entry per cycle into the register bank's single write port.
module wb_arbiter #(
    parameter int WIDTH        = 32,
    parameter int REG_SEL      = 5,
    parameter int PRED_REG_SEL = 3,
    parameter int DEPTH        = 4
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [REG_SEL-1:0]       alu_addr,
    input  logic                     alu_sel,
    input  logic [WIDTH-1:0]         alu_data,

    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [REG_SEL-1:0]       mem_addr,
    input  logic                     mem_sel,
    input  logic [WIDTH-1:0]         mem_data,

    output logic                     write_enable,
    output logic [REG_SEL-1:0]       addr_z,
    output logic                     z_regbank_sel,
    output logic [WIDTH-1:0]         data_z,

    input  logic [REG_SEL-1:0]       hz_addr,
    input  logic                     hz_sel,
    output logic                     hz_pending,

    output logic [$clog2(DEPTH):0]   count
);

    localparam int   PW     = $clog2(DEPTH);
    localparam int   CW     = PW + 1;
    localparam logic P_REGS = 1'b1;

    typedef enum logic {
        RR_ALU = 1'b0,
        RR_MEM = 1'b1
    } rr_e;

    logic [REG_SEL-1:0] addr_mem [DEPTH];
    logic               sel_mem  [DEPTH];
    logic [WIDTH-1:0]   data_mem [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] mem_wr_idx;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] space;
    rr_e           rr_q, rr_d;
    logic          pop, push_alu, push_mem, contested;

    // The bank never stalls, so the head leaves on every edge the FIFO is
    // non-empty; that departing slot is reusable by this cycle's pushes.
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every
        // path (defaults first), otherwise synthesis infers a latch.
        alu_ready = 1'b1;
        mem_ready = 1'b1;
        rr_d      = rr_q;

        pop       = (count_q != '0);
        space     = CW'(DEPTH) - count_q + CW'(pop);
        contested = alu_valid && mem_valid && (space == CW'(1));

        if (space < CW'(2)) begin
            alu_ready = !mem_valid || (rr_q == RR_ALU);
            mem_ready = !alu_valid || (rr_q == RR_MEM);
        end

        push_alu   = alu_valid && alu_ready;
        push_mem   = mem_valid && mem_ready;
        mem_wr_idx = wr_ptr_q + PW'(push_alu);
        wr_ptr_d   = mem_wr_idx + PW'(push_mem);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        count_d    = count_q + CW'(push_alu) + CW'(push_mem) - CW'(pop);

        if (contested) begin
            rr_d = (rr_q == RR_ALU) ? RR_MEM : RR_ALU;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            rr_q     <= RR_ALU;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            rr_q     <= rr_d;
        end
    end

    // NOTE: the storage array has no reset; occupancy is tracked by count_q
    // and every read of the array is qualified by it.
    always_ff @(posedge clk) begin
        if (push_alu) begin
            addr_mem[wr_ptr_q] <= alu_addr;
            sel_mem[wr_ptr_q]  <= alu_sel;
            data_mem[wr_ptr_q] <= alu_data;
        end
        if (push_mem) begin
            addr_mem[mem_wr_idx] <= mem_addr;
            sel_mem[mem_wr_idx]  <= mem_sel;
            data_mem[mem_wr_idx] <= mem_data;
        end
    end

    always_comb begin
        write_enable  = pop;
        addr_z        = '0;
        z_regbank_sel = 1'b0;
        data_z        = '0;
        if (pop) begin
            addr_z        = addr_mem[rd_ptr_q];
            z_regbank_sel = sel_mem[rd_ptr_q];
            data_z        = data_mem[rd_ptr_q];
        end
    end

    // A slot is live when its distance from the head is below the occupancy;
    // predicate registers only decode the low PRED_REG_SEL address bits.
    always_comb begin
        hz_pending = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (({1'b0, (PW'(i) - rd_ptr_q)} < count_q) && (sel_mem[i] == hz_sel)) begin
                if (hz_sel == P_REGS) begin
                    if (addr_mem[i][PRED_REG_SEL-1:0] == hz_addr[PRED_REG_SEL-1:0]) begin
                        hz_pending = 1'b1;
                    end
                end else if (addr_mem[i] == hz_addr) begin
                    hz_pending = 1'b1;
                end
            end
        end
    end

    assign count = count_q;

endmodule
